// File: rtl/spi_slave_port_if.sv
// Byte-side handshake bundle of spi_slave_port: TX/RX ready-valid channels and status pulses.
interface spi_slave_port_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       tx_underrun_o;
  logic       rx_overrun_o;
  logic       frame_abort_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, rx_overrun_o, frame_abort_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, rx_overrun_o, frame_abort_o
  );
endinterface

// File: rtl/spi_slave_port.sv
// SPI slave port, all four modes, MSB first, oversampled in the clk_i domain.
// Optional macro SPI_SLAVE_PORT_RX_FIFO_EN: 4-entry RX FIFO instead of a single RX holding register.
module spi_slave_port #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ss_i,
  input  logic mosi_i,
  input  logic cpol_i,
  input  logic cpha_i,
  output logic miso_o,
  output logic miso_oe_o,
  spi_slave_port_if.slave bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic             sck_prev_q, sck_prev_d;
  logic             cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, tx_hold_q, tx_hold_d;
  logic             tx_full_q, tx_full_d;
  logic             ur_pend_q, ur_pend_d;
  logic             miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic             tx_underrun_q, tx_underrun_d, frame_abort_q, frame_abort_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             rx_push_c, rx_pop_c;
  logic [DW-1:0]    rx_push_data_c, tx_byte_c;
  logic             sck_s, ss_s, mosi_s, sck_edge_c, lead_c, trail_c, sample_c, shift_c;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edge classification against the CPOL idle level latched at frame start
  assign sck_edge_c = sck_s ^ sck_prev_q;
  assign lead_c     = sck_edge_c && (sck_prev_q == cpol_q);
  assign trail_c    = sck_edge_c && (sck_s == cpol_q);
  assign sample_c   = cpha_q ? trail_c : lead_c;
  assign shift_c    = cpha_q ? lead_c : trail_c;
  assign tx_byte_c  = tx_full_q ? tx_hold_q : 8'hFF;

  // Synchroniser chains for the asynchronous SPI pins
  always_comb begin
    sck_sync_d  = SYNC_STAGES'({sck_sync_q, sck_i});
    ss_sync_d   = SYNC_STAGES'({ss_sync_q, ss_i});
    mosi_sync_d = SYNC_STAGES'({mosi_sync_q, mosi_i});
    sck_prev_d  = sck_s;
  end

  // Frame FSM, shift registers, TX holding register and status pulses
  always_comb begin
    state_d        = state_q;
    cpol_d         = cpol_q;
    cpha_d         = cpha_q;
    bit_cnt_d      = bit_cnt_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    tx_hold_d      = tx_hold_q;
    tx_full_d      = tx_full_q;
    ur_pend_d      = ur_pend_q;
    miso_d         = miso_q;
    tx_underrun_d  = 1'b0;
    frame_abort_d  = 1'b0;
    rx_push_c      = 1'b0;
    rx_push_data_c = {rx_sr_q[DW-2:0], mosi_s};

    if (bus.tx_valid_i && !tx_full_q) begin
      tx_hold_d = bus.tx_data_i;
      tx_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        cpol_d    = cpol_i;
        cpha_d    = cpha_i;
        bit_cnt_d = '0;
        ur_pend_d = 1'b0;
        if (!ss_s) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        if (tx_full_q) tx_full_d = 1'b0;
        else           tx_underrun_d = 1'b1;
        // CPHA=0 presents bit 7 now; CPHA=1 presents it on the first leading edge
        miso_d  = tx_byte_c[DW-1];
        tx_sr_d = cpha_q ? tx_byte_c : {tx_byte_c[DW-2:0], 1'b0};
      end
      ST_SHIFT: begin
        if (ss_s) begin
          state_d       = ST_IDLE;
          frame_abort_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          ur_pend_d     = 1'b0;
        end else if (sample_c) begin
          rx_sr_d   = rx_push_data_c;
          bit_cnt_d = bit_cnt_q + 3'd1;
          // A filler byte is only reported once its first bit is really clocked
          if ((bit_cnt_q == '0) && ur_pend_q) begin
            tx_underrun_d = 1'b1;
            ur_pend_d     = 1'b0;
          end
          if (bit_cnt_q == CW'(DW-1)) begin
            rx_push_c = 1'b1;
            tx_sr_d   = tx_byte_c;
            ur_pend_d = !tx_full_q;
            if (tx_full_q) tx_full_d = 1'b0;
          end
        end else if (shift_c) begin
          miso_d  = tx_sr_q[DW-1];
          tx_sr_d = {tx_sr_q[DW-2:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miso_oe_d = (state_d != ST_IDLE);
    if (state_d == ST_IDLE) miso_d = 1'b0;
  end

  // Core register bank
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      sck_sync_q    <= '0;
      ss_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sck_prev_q    <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      tx_hold_q     <= '0;
      tx_full_q     <= 1'b0;
      ur_pend_q     <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sck_prev_q    <= sck_prev_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      tx_hold_q     <= tx_hold_d;
      tx_full_q     <= tx_full_d;
      ur_pend_q     <= ur_pend_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

`ifdef SPI_SLAVE_PORT_RX_FIFO_EN
  localparam int unsigned RX_DEPTH = 4;
  localparam int unsigned PW       = 2;

  logic [DW-1:0] rx_mem_q [RX_DEPTH];
  logic [DW-1:0] rx_mem_d [RX_DEPTH];
  logic [PW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [PW:0]   rx_cnt_q, rx_cnt_d;
  logic          rx_wr_en_c;

  // RX FIFO; a full FIFO still accepts a push in the cycle it is popped
  always_comb begin
    rx_mem_d     = rx_mem_q;
    rx_rd_d      = rx_rd_q;
    rx_wr_d      = rx_wr_q;
    rx_overrun_d = 1'b0;
    rx_pop_c     = (rx_cnt_q != '0) && bus.rx_ready_i;
    rx_wr_en_c   = rx_push_c && ((rx_cnt_q != (PW+1)'(RX_DEPTH)) || rx_pop_c);
    if (rx_pop_c) rx_rd_d = rx_rd_q + 2'd1;
    if (rx_wr_en_c) begin
      rx_mem_d[rx_wr_q] = rx_push_data_c;
      rx_wr_d           = rx_wr_q + 2'd1;
    end
    if (rx_push_c && !rx_wr_en_c) rx_overrun_d = 1'b1;
    rx_cnt_d = rx_cnt_q + (PW+1)'(rx_wr_en_c) - (PW+1)'(rx_pop_c);
  end

  // RX FIFO storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RX_DEPTH); i++) rx_mem_q[i] <= '0;
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      rx_mem_q <= rx_mem_d;
      rx_rd_q  <= rx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign bus.rx_valid_o = (rx_cnt_q != '0);
  assign bus.rx_data_o  = rx_mem_q[rx_rd_q];
`else
  logic [DW-1:0] rx_hold_q, rx_hold_d;
  logic          rx_full_q, rx_full_d;

  // Single RX holding register; pop and push in one cycle both succeed
  always_comb begin
    rx_hold_d    = rx_hold_q;
    rx_full_d    = rx_full_q;
    rx_overrun_d = 1'b0;
    rx_pop_c     = rx_full_q && bus.rx_ready_i;
    if (rx_pop_c) rx_full_d = 1'b0;
    if (rx_push_c) begin
      if (!rx_full_q || rx_pop_c) begin
        rx_hold_d = rx_push_data_c;
        rx_full_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  // RX holding register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_hold_q <= '0;
      rx_full_q <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
    end
  end

  assign bus.rx_valid_o = rx_full_q;
  assign bus.rx_data_o  = rx_hold_q;
`endif

  assign miso_o            = miso_q;
  assign miso_oe_o         = miso_oe_q;
  assign bus.tx_ready_o    = !tx_full_q;
  assign bus.tx_underrun_o = tx_underrun_q;
  assign bus.rx_overrun_o  = rx_overrun_q;
  assign bus.frame_abort_o = frame_abort_q;
endmodule
